// File: rtl/mult_booth_seq.sv
// -----------------------------------------------------------------------------
// mult_booth_seq
//   Sequential signed 32x32 radix-2 Booth multiplier for the ALU multdiv path.
//   One Booth iteration per cycle; each add/subtract goes through the 32-bit
//   carry-lookahead adder cla_32, with a 33rd accumulator bit kept outside the
//   adder so that M = 0x80000000 is handled exactly. The 64-bit product is
//   available 33 cycles after the start edge.
//
// Ports
//   clock           in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   ctrl_MULT       in   start pulse; operands sampled on the same edge
//   data_operandA   in   multiplicand (two's complement)
//   data_operandB   in   multiplier (two's complement)
//   data_result     out  product[31:0]
//   data_result_hi  out  product[63:32]
//   data_exception  out  product is not the sign extension of product[31:0]
//   data_resultRDY  out  one-cycle pulse while result/exception are fresh
//   busy            out  high while iterating
//
// cla_32
//   32-bit carry-lookahead adder: 4-bit lookahead groups whose group
//   generate/propagate terms chain the group carries.
//   Ports: a, b (addends), cin (carry in), sum, cout (carry out of bit 31).
// -----------------------------------------------------------------------------

module cla_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  // Returns {carry_out, sum}. Locals live in the function so the carry chain
  // never reads back a module-level net it also drives.
  function automatic logic [32:0] cla_add(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic        ci);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic        grp_g;
    logic        grp_p;
    int          base;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int j = 0; j < 8; j++) begin
      base = 4 * j;
      c[base+1] = g[base] | (p[base] & c[base]);
      c[base+2] = g[base+1] | (p[base+1] & g[base]) | (p[base+1] & p[base] & c[base]);
      c[base+3] = g[base+2] | (p[base+2] & g[base+1]) | (p[base+2] & p[base+1] & g[base])
                | (p[base+2] & p[base+1] & p[base] & c[base]);
      grp_g = g[base+3] | (p[base+3] & g[base+2]) | (p[base+3] & p[base+2] & g[base+1])
            | (p[base+3] & p[base+2] & p[base+1] & g[base]);
      grp_p = &p[base+:4];
      c[base+4] = grp_g | (grp_p & c[base]);
    end
    return {c[32], p ^ c[31:0]};
  endfunction

  assign {cout, sum} = cla_add(a, b, cin);

endmodule

module mult_booth_seq #(
  parameter int WIDTH = 32,  // fixed to the cla_32 width
  parameter int CNT_W = 6    // must be able to hold WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;        // multiplicand
  logic [WIDTH:0]     acc_q, acc_d;    // 33-bit upper half of the working register
  logic [WIDTH-1:0]   q_q, q_d;        // multiplier / low product half
  logic               qm1_q, qm1_d;    // Booth look-behind bit
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               exc_q, exc_d;

  // Booth datapath for the current iteration
  logic [1:0]         booth_sel;
  logic               is_sub;
  logic [WIDTH-1:0]   cla_b;
  logic [WIDTH-1:0]   cla_sum;
  logic               cla_cout;
  logic [WIDTH:0]     acc_sum;
  logic [WIDTH:0]     acc_sh;
  logic [WIDTH-1:0]   q_sh;
  logic [WIDTH:0]     prod_top;        // product bits [63:31] after this iteration

  assign booth_sel = {q_q[0], qm1_q};
  assign is_sub    = (booth_sel == 2'b10);
  // Subtraction is A + ~M + 1; the inverted operand also supplies the
  // sign-extension bit for the 33rd accumulator bit.
  assign cla_b     = is_sub ? ~m_q : m_q;

  cla_32 u_cla (
    .a    (acc_q[WIDTH-1:0]),
    .b    (cla_b),
    .cin  (is_sub),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    acc_sum = acc_q;
    if (booth_sel[1] ^ booth_sel[0]) begin
      acc_sum = {acc_q[WIDTH] ^ cla_b[WIDTH-1] ^ cla_cout, cla_sum};
    end
    // Arithmetic right shift of {acc_sum, q, q_m1} by one.
    acc_sh   = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    q_sh     = {acc_sum[0], q_q[WIDTH-1:1]};
    prod_top = {acc_sh[WIDTH-1:0], q_sh[WIDTH-1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    acc_d    = acc_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    exc_d    = exc_q;

    if (ctrl_MULT) begin
      // A start in any state (re)loads the operands; an in-flight
      // operation is abandoned without a result.
      state_d = RUN;
      cnt_d   = '0;
      m_d     = data_operandA;
      acc_d   = '0;
      q_d     = data_operandB;
      qm1_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          acc_d = acc_sh;
          q_d   = q_sh;
          qm1_d = q_q[0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DONE;
            res_lo_d = q_sh;
            res_hi_d = acc_sh[WIDTH-1:0];
            // Fits in 32 bits only if bits 63..31 are all ones or all zeros.
            exc_d    = ~((&prod_top) | ~(|prod_top));
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the whole datapath is cleared by reset, including result registers, so outputs are 0 after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = res_lo_q;
  assign data_result_hi = res_hi_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_mult_booth_seq.sv
// -----------------------------------------------------------------------------
// tb_mult_booth_seq
//   Self-checking bench for mult_booth_seq. A transaction-level model (signed
//   64-bit multiply plus a countdown to the ready pulse) predicts every output
//   after every rising edge; directed cases also check known constants.
// -----------------------------------------------------------------------------
module tb_mult_booth_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] data_result;
  logic [31:0] data_result_hi;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  mult_booth_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (data_result),
    .data_result_hi (data_result_hi),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  int start_edge = 0;

  // Reference model state
  bit          m_pend   = 1'b0;
  int          m_remain = 0;
  logic [63:0] m_prod   = '0;
  logic [31:0] e_lo     = '0;
  logic [31:0] e_hi     = '0;
  logic        e_exc    = 1'b0;
  logic        e_rdy    = 1'b0;
  logic        e_busy   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic exc_of(input logic [63:0] p);
    return p != {{32{p[31]}}, p[31:0]};
  endfunction

  task automatic model_clear();
    m_pend = 1'b0; m_remain = 0;
    e_lo = '0; e_hi = '0; e_exc = 1'b0; e_rdy = 1'b0; e_busy = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs the DUT sampled.
  task automatic model_edge();
    if (!reset_n) begin
      model_clear();
    end else begin
      e_rdy = 1'b0;
      if (ctrl_MULT) begin
        m_pend   = 1'b1;
        m_remain = 32;
        m_prod   = longint'($signed(op_a)) * longint'($signed(op_b));
      end else if (m_pend) begin
        m_remain--;
        if (m_remain == 0) begin
          m_pend = 1'b0;
          e_rdy  = 1'b1;
          e_lo   = m_prod[31:0];
          e_hi   = m_prod[63:32];
          e_exc  = exc_of(m_prod);
        end
      end
      e_busy = m_pend;
    end
  endtask

  task automatic check_outputs();
    check("rdy",  64'(data_resultRDY), 64'(e_rdy));
    check("busy", 64'(busy),           64'(e_busy));
    check("lo",   64'(data_result),    64'(e_lo));
    check("hi",   64'(data_result_hi), 64'(e_hi));
    check("exc",  64'(data_exception), 64'(e_exc));
  endtask

  task automatic tick();
    @(posedge clock);
    edge_cnt++;
    model_edge();
    #1;
    check_outputs();
  endtask

  // Start pulse sampled on the next edge; operands are scrambled afterwards
  // because the DUT must ignore them outside start edges.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = 1'b1; op_a = a; op_b = b;
    tick();
    start_edge = edge_cnt;
    ctrl_MULT = 1'b0; op_a = $urandom; op_b = $urandom;
  endtask

  // Latency reported as the edge that samples the RDY pulse minus the start edge.
  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_resultRDY) begin
        lat = edge_cnt - start_edge + 1;
        break;
      end
    end
    if (lat < 0) check("rdy_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'($signed($urandom_range(0, 200)) - 100);
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int rdy_seen;

    // Power-on reset
    model_clear();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1. Reset during iteration 12, released three cycles later.
    launch(32'd1234, 32'd5678);
    repeat (12) tick();
    #2 reset_n = 1'b0;
    model_clear();
    #1 check_outputs();
    repeat (3) tick();
    reset_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_resultRDY) rdy_seen++;
    end
    check("rst_no_rdy", 64'(rdy_seen), 64'd0);
    check("rst_lo", 64'(data_result), 64'd0);

    // 2. 7 * -3
    launch(32'd7, 32'hFFFF_FFFD);
    wait_rdy(lat);
    check("t2_lat", 64'(lat), 64'd33);
    check("t2_lo",  64'(data_result),    64'hFFFF_FFEB);
    check("t2_hi",  64'(data_result_hi), 64'hFFFF_FFFF);
    check("t2_exc", 64'(data_exception), 64'd0);
    tick();
    check("t2_rdy_once", 64'(data_resultRDY), 64'd0);

    // 3. -2^31 * -1
    launch(32'h8000_0000, 32'hFFFF_FFFF);
    wait_rdy(lat);
    check("t3_lo",  64'(data_result),    64'h8000_0000);
    check("t3_hi",  64'(data_result_hi), 64'h0000_0000);
    check("t3_exc", 64'(data_exception), 64'd1);
    tick();

    // 4. -2^31 * -2^31
    launch(32'h8000_0000, 32'h8000_0000);
    wait_rdy(lat);
    check("t4_lo",  64'(data_result),    64'h0000_0000);
    check("t4_hi",  64'(data_result_hi), 64'h4000_0000);
    check("t4_exc", 64'(data_exception), 64'd1);
    tick();

    // 5. Abort 5*5 with 6*7 ten edges later; only one RDY.
    launch(32'd5, 32'd5);
    lat = start_edge;
    repeat (9) tick();
    launch(32'd6, 32'd7);
    check("t5_restart_edge", 64'(start_edge - lat), 64'd10);
    wait_rdy(lat);
    check("t5_lat", 64'(lat), 64'd33);
    check("t5_lo",  64'(data_result),    64'd42);
    check("t5_exc", 64'(data_exception), 64'd0);
    rdy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (data_resultRDY) rdy_seen++;
    end
    check("t5_single_rdy", 64'(rdy_seen), 64'd0);

    // 6. New start during the DONE cycle of 3*4.
    launch(32'd3, 32'd4);
    wait_rdy(lat);
    check("t6a_lo", 64'(data_result), 64'd12);
    launch(32'hFFFF_FFFE, 32'hFFFF_FFFE);
    check("t6_busy", 64'(busy), 64'd1);
    check("t6_hold_lo", 64'(data_result), 64'd12);
    wait_rdy(lat);
    check("t6_lat", 64'(lat), 64'd33);
    check("t6b_lo", 64'(data_result),    64'd4);
    check("t6b_hi", 64'(data_result_hi), 64'd0);
    tick();

    // 7. Random operands, occasional aborts, back-to-back starts in DONE.
    for (int n = 0; n < 2000; n++) begin
      launch(pick_operand(), pick_operand());
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 30)) tick();
        launch(pick_operand(), pick_operand());
      end
      wait_rdy(lat);
      if (lat >= 0) check("rand_lat", 64'(lat), 64'd33);
      if ($urandom_range(0, 1) == 1) tick();
    end
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
